// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the data memory responder
package data_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;
  localparam int CNT_W      = 4;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/data_mem_responder_mem_array.sv
// rtl/data_mem_responder_mem_array.sv - single-port synchronous RAM, registered read
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read register only moves on an enabled read, so it holds across the response phase.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - request/response front end with wait states and preload port
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid, r_rsp_err, r_rd_sel;

  logic              w_accept, w_req_in_range, w_ld_in_range;
  logic              w_ram_en, w_ram_we;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;

  assign w_req_in_range = 32'(r_addr) < 32'(DEPTH);
  assign w_ld_in_range  = 32'(ld_addr) < 32'(DEPTH);
  assign req_ready      = (r_state == ST_IDLE) && !ld_en;
  assign w_accept       = req_valid && req_ready;
  assign busy           = (r_state != ST_IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_err        = r_rsp_err;
  assign rsp_rdata      = r_rd_sel ? w_ram_rdata : '0;

  always_comb begin
    w_next      = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_addr[IDX_W-1:0];
    w_ram_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (ld_en) begin
          w_ram_en    = w_ld_in_range;
          w_ram_we    = 1'b1;
          w_ram_addr  = ld_addr[IDX_W-1:0];
          w_ram_wdata = ld_wdata;
        end
        if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: if (r_cnt == CNT_W'(1)) w_next = ST_ACCESS;
      ST_ACCESS: begin
        w_ram_en = w_req_in_range;
        w_ram_we = r_we;
        w_next   = ST_RESP;
      end
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_W'(WAIT_CYCLES);
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == ST_ACCESS) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= !w_req_in_range;
        r_rd_sel    <= w_req_in_range && !r_we;
      end
      if (r_state == ST_RESP && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk    (clk1),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for the default and zero-wait responders
module tb_data_mem_responder;
  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        ld_en_a = 1'b0, ld_en_b = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;

  logic        rdy_a, va, err_a, busy_a;
  logic        rdy_b, vb, err_b, busy_b;
  logic [31:0] rd_a, rd_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  data_mem_responder #(.WAIT_CYCLES(2)) dut_a (
    .clk1(clk1), .rst(rst), .req_valid(req_valid_a), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(va), .rsp_ready(rsp_ready),
    .rsp_rdata(rd_a), .rsp_err(err_a), .ld_en(ld_en_a), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .busy(busy_a)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk1(clk1), .rst(rst), .req_valid(req_valid_b), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vb), .rsp_ready(rsp_ready),
    .rsp_rdata(rd_b), .rsp_err(err_b), .ld_en(ld_en_b), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [15:0] addr, input logic [31:0] data);
    ld_addr = addr;
    ld_wdata = data;
    if (sel) ld_en_b = 1'b1; else ld_en_a = 1'b1;
    @(posedge clk1); #1;
    ld_en_a = 1'b0;
    ld_en_b = 1'b0;
  endtask

  // Issues one request, scrambles the request inputs after acceptance, waits for the response.
  task automatic do_req(input bit sel, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int acc);
    int n;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    n = 0;
    while (!(sel ? rdy_b : rdy_a) && n < 20) begin
      @(posedge clk1); #1;
      n++;
    end
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk1); #1;
    acc = cyc;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_we = ~we;
    req_addr = ~addr;
    req_wdata = ~wd;
    lat = 0;
    while (!(sel ? vb : va) && lat < 40) begin
      @(posedge clk1); #1;
      lat++;
    end
    rd = sel ? rd_b : rd_a;
    err = sel ? err_b : err_a;
    @(posedge clk1); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    logic        err;
    int          lat, acc0, acc1, n;

    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    chk("reset rsp_valid", {31'd0, va}, 32'd0);
    chk("reset rsp_rdata", rd_a, 32'd0);
    chk("reset rsp_err", {31'd0, err_a}, 32'd0);
    chk("reset req_ready", {31'd0, rdy_a}, 32'd1);
    chk("reset busy", {31'd0, busy_a}, 32'd0);

    ld_addr = 16'd5;
    ld_wdata = 32'hDEADBEEF;
    ld_en_a = 1'b1;
    #1;
    chk("ld_en blocks req_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk1); #1;
    ld_en_a = 1'b0;
    preload(0, 16'd0, 32'h11111111);
    preload(0, 16'd1023, 32'h22222222);
    preload(0, 16'd3, 32'h33333333);
    preload(0, 16'd20, 32'h000000A0);
    preload(0, 16'd1024, 32'hBADBAD00);

    do_req(0, 1'b0, 16'd5, 32'h0, rd, err, lat, acc0);
    chk("preload read latency", lat, 3);
    chk("preload read data", rd, 32'hDEADBEEF);
    chk("preload read err", {31'd0, err}, 32'd0);

    do_req(0, 1'b1, 16'd12, 32'h00000042, rd, err, lat, acc0);
    chk("write rsp rdata", rd, 32'd0);
    chk("write rsp err", {31'd0, err}, 32'd0);
    do_req(0, 1'b0, 16'd12, 32'h0, rd, err, lat, acc1);
    chk("store-load data", rd, 32'h00000042);
    chk("request spacing", acc1 - acc0, 5);

    rsp_ready = 1'b0;
    req_we = 1'b0;
    req_addr = 16'd5;
    req_valid_a = 1'b1;
    @(posedge clk1); #1;
    req_valid_a = 1'b0;
    n = 0;
    while (!va && n < 20) begin
      @(posedge clk1); #1;
      n++;
    end
    chk("backpressure latency", n, 3);
    held = rd_a;
    chk("backpressure data", held, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk1); #1;
      chk("bp rsp_valid held", {31'd0, va}, 32'd1);
      chk("bp rdata stable", rd_a, held);
      chk("bp err stable", {31'd0, err_a}, 32'd0);
      chk("bp req_ready low", {31'd0, rdy_a}, 32'd0);
      chk("bp busy high", {31'd0, busy_a}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk1); #1;
    chk("bp rsp_valid cleared", {31'd0, va}, 32'd0);
    chk("bp req_ready after handshake", {31'd0, rdy_a}, 32'd1);
    chk("bp busy after handshake", {31'd0, busy_a}, 32'd0);

    do_req(0, 1'b0, 16'd1024, 32'h0, rd, err, lat, acc0);
    chk("oor read err", {31'd0, err}, 32'd1);
    chk("oor read rdata", rd, 32'd0);
    do_req(0, 1'b1, 16'hFFFF, 32'h5A5A5A5A, rd, err, lat, acc0);
    chk("oor write err", {31'd0, err}, 32'd1);
    chk("oor write rdata", rd, 32'd0);
    do_req(0, 1'b0, 16'd0, 32'h0, rd, err, lat, acc0);
    chk("mem[0] unchanged", rd, 32'h11111111);
    do_req(0, 1'b0, 16'd1023, 32'h0, rd, err, lat, acc0);
    chk("mem[1023] unchanged", rd, 32'h22222222);
    chk("mem[1023] err", {31'd0, err}, 32'd0);

    ld_addr = 16'd7;
    ld_wdata = 32'h00000077;
    ld_en_a = 1'b1;
    req_we = 1'b0;
    req_addr = 16'd7;
    req_valid_a = 1'b1;
    #1;
    chk("collision req_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk1); #1;
    ld_en_a = 1'b0;
    #1;
    chk("collision not accepted", {31'd0, busy_a}, 32'd0);
    chk("collision ready next", {31'd0, rdy_a}, 32'd1);
    req_valid_a = 1'b0;
    do_req(0, 1'b0, 16'd7, 32'h0, rd, err, lat, acc0);
    chk("collision read latency", lat, 3);
    chk("collision preload data", rd, 32'h00000077);

    req_we = 1'b0;
    req_addr = 16'd20;
    req_valid_a = 1'b1;
    @(posedge clk1); #1;
    req_valid_a = 1'b0;
    ld_addr = 16'd20;
    ld_wdata = 32'h00000BAD;
    ld_en_a = 1'b1;
    @(posedge clk1); #1;
    ld_en_a = 1'b0;
    n = 0;
    while (!va && n < 20) begin
      @(posedge clk1); #1;
      n++;
    end
    chk("busy preload ignored rsp", rd_a, 32'h000000A0);
    @(posedge clk1); #1;
    do_req(0, 1'b0, 16'd20, 32'h0, rd, err, lat, acc0);
    chk("busy preload ignored mem", rd, 32'h000000A0);

    req_we = 1'b1;
    req_addr = 16'd3;
    req_wdata = 32'hFFFF0000;
    req_valid_a = 1'b1;
    @(posedge clk1); #1;
    req_valid_a = 1'b0;
    chk("mid-write busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    chk("mid-reset rsp_valid", {31'd0, va}, 32'd0);
    chk("mid-reset rsp_rdata", rd_a, 32'd0);
    chk("mid-reset rsp_err", {31'd0, err_a}, 32'd0);
    chk("mid-reset busy", {31'd0, busy_a}, 32'd0);
    chk("mid-reset req_ready", {31'd0, rdy_a}, 32'd1);
    repeat (4) @(posedge clk1);
    #1;
    chk("dropped rsp_valid", {31'd0, va}, 32'd0);
    do_req(0, 1'b0, 16'd3, 32'h0, rd, err, lat, acc0);
    chk("mem[3] retained", rd, 32'h33333333);

    preload(1, 16'd9, 32'h00000099);
    do_req(1, 1'b0, 16'd9, 32'h0, rd, err, lat, acc0);
    chk("zero-wait latency", lat, 1);
    chk("zero-wait data", rd, 32'h00000099);
    do_req(1, 1'b1, 16'd9, 32'h00000055, rd, err, lat, acc0);
    do_req(1, 1'b0, 16'd9, 32'h0, rd, err, lat, acc1);
    chk("zero-wait store-load", rd, 32'h00000055);
    chk("zero-wait spacing", acc1 - acc0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
